// File: rtl/vgagraph_pkg.sv
// rtl/vgagraph_pkg.sv - shared constants and fetch FSM state for the vgagraph display path
package vgagraph_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int PPW       = 4;
    localparam int FRAME_WDS = H_VISIBLE * V_VISIBLE / PPW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/vgagraph_wfifo.sv
// rtl/vgagraph_wfifo.sv - synchronous word FIFO with push/pop/count and synchronous flush
module vgagraph_wfifo #(
    parameter int DATA_W = 32,
    parameter int LG     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [LG:0]       count,
    output logic              empty
);

    localparam int CW = LG + 1;

    logic [DATA_W-1:0] mem_q [2**LG];
    logic [LG-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LG-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + LG'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + LG'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);

endmodule

// File: rtl/vgagraph_pixfetch.sv
// rtl/vgagraph_pixfetch.sv - frame-buffer prefetcher and pixel unpacker for the VGA output stage
module vgagraph_pixfetch #(
    parameter int                ADDR_W    = 19,
    parameter int                DATA_W    = 32,
    parameter int                PIX_W     = 8,
    parameter int                FIFO_LG   = 4,
    parameter int                FRAME_WDS = vgagraph_pkg::FRAME_WDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [PIX_W-1:0]  UNDER_PIX = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LOAD,
    input  logic              RDENABLE,
    output logic              MREQ,
    output logic [ADDR_W-1:0] MADDR,
    input  logic              MACK,
    input  logic              MVALID,
    input  logic [DATA_W-1:0] MDATA,
    output logic [PIX_W-1:0]  PIXEL,
    output logic              UNDERFLOW
);
    import vgagraph_pkg::*;

    localparam int WORD_PIX = DATA_W / PIX_W;
    localparam int IDX_W    = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;
    localparam int ISS_W    = $clog2(FRAME_WDS) + 1;
    localparam int CNT_W    = FIFO_LG + 1;
    localparam int DEPTH    = 2 ** FIFO_LG;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [ISS_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              load_q, load_d;
    logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d;
    logic              underflow_q, underflow_d;

    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              fifo_push;
    logic              credit_ok;
    logic              mreq;
    logic              ack;
    logic              take;

    // Credit covers words in the FIFO plus words of this frame still in flight,
    // so every returned word is guaranteed a slot.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outst_q}) < (CNT_W + 1)'(DEPTH);
    assign mreq      = (state_q == FETCH) && !load_q && (issued_q != ISS_W'(FRAME_WDS)) && credit_ok;
    assign ack       = mreq && MACK;
    assign take      = MVALID && (drop_q == '0);
    assign fifo_push = take && !LOAD;

    vgagraph_wfifo #(
        .DATA_W (DATA_W),
        .LG     (FIFO_LG)
    ) u_wfifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .flush   (LOAD),
        .push    (fifo_push),
        .wr_data (MDATA),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        maddr_d     = maddr_q;
        issued_d    = issued_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        load_d      = LOAD;
        pix_idx_d   = pix_idx_q;
        pixel_d     = pixel_q;
        underflow_d = underflow_q;
        fifo_pop    = 1'b0;

        if (LOAD) begin
            // Everything in flight, including an accept this cycle, belongs to the old frame.
            state_d     = FETCH;
            maddr_d     = BASE_ADDR;
            issued_d    = '0;
            outst_d     = '0;
            drop_d      = drop_q + outst_q + CNT_W'(ack) - CNT_W'(MVALID);
            pix_idx_d   = '0;
            underflow_d = 1'b0;
        end else begin
            if (ack) begin
                maddr_d  = maddr_q + ADDR_W'(1);
                issued_d = issued_q + ISS_W'(1);
            end
            outst_d = outst_q + CNT_W'(ack) - CNT_W'(take);
            if (MVALID && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
            if ((state_q == FETCH) && (issued_q == ISS_W'(FRAME_WDS))) state_d = DONE;

            if (RDENABLE) begin
                if (!fifo_empty) begin
                    pixel_d = fifo_head[int'(pix_idx_q) * PIX_W +: PIX_W];
                    if (pix_idx_q == IDX_W'(WORD_PIX - 1)) begin
                        pix_idx_d = '0;
                        fifo_pop  = 1'b1;
                    end else begin
                        pix_idx_d = pix_idx_q + IDX_W'(1);
                    end
                end else begin
                    pixel_d     = UNDER_PIX;
                    underflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            maddr_q     <= BASE_ADDR;
            issued_q    <= '0;
            outst_q     <= '0;
            drop_q      <= '0;
            load_q      <= 1'b0;
            pix_idx_q   <= '0;
            pixel_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            maddr_q     <= maddr_d;
            issued_q    <= issued_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            load_q      <= load_d;
            pix_idx_q   <= pix_idx_d;
            pixel_q     <= pixel_d;
            underflow_q <= underflow_d;
        end
    end

    assign MREQ      = mreq;
    assign MADDR     = maddr_q;
    assign PIXEL     = pixel_q;
    assign UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_vgagraph_pixfetch.sv
// tb/tb_vgagraph_pixfetch.sv - self-checking bench for vgagraph_pixfetch
module tb_vgagraph_pixfetch;
    import vgagraph_pkg::*;

    localparam int AW  = 19;
    localparam int DW  = 32;
    localparam int PW  = 8;
    localparam int FRM = 480;
    localparam logic [AW-1:0] BASE = '0;

    logic          CLK = 1'b0;
    logic          RST_N, LOAD, RDENABLE, MACK, MVALID;
    logic [DW-1:0] MDATA;
    logic          MREQ, UNDERFLOW;
    logic [AW-1:0] MADDR;
    logic [PW-1:0] PIXEL;

    int checks = 0;
    int errors = 0;

    vgagraph_pixfetch #(
        .ADDR_W(AW), .DATA_W(DW), .PIX_W(PW), .FIFO_LG(4),
        .FRAME_WDS(FRM), .BASE_ADDR(BASE), .UNDER_PIX(8'h00)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .RDENABLE(RDENABLE),
        .MREQ(MREQ), .MADDR(MADDR), .MACK(MACK), .MVALID(MVALID), .MDATA(MDATA),
        .PIXEL(PIXEL), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] word_of(input int addr);
        return DW'(addr) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    function automatic logic [PW-1:0] pix_of(input int w, input int k);
        logic [DW-1:0] d;
        d = word_of(int'(BASE) + w);
        return d[k*PW +: PW];
    endfunction

    // Memory: accepts per ack_pct, answers in order after mem_lat cycles, data = word_of(addr).
    int mem_lat = 2;
    int ack_pct = 100;
    int cyc = 0;
    int pend_addr[$];
    int pend_due[$];

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_addr.delete();
            pend_due.delete();
            MACK   = 1'b0;
            MVALID = 1'b0;
        end else begin
            cyc++;
            #1;
            MVALID = 1'b0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                MVALID = 1'b1;
                MDATA  = word_of(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            MACK = MREQ && ($urandom_range(99) < ack_pct);
            if (MACK) begin
                pend_addr.push_back(int'(MADDR));
                pend_due.push_back(cyc + mem_lat);
            end
        end
    end

    // Reference model: each accepted request is tagged with the frame it belongs to; a reply
    // counts only if its tag is the current frame. Pixel n of a frame is byte n%4 of word n/4,
    // available once that word has arrived in an earlier cycle.
    int gen, mcyc, npix, issued;
    int tagq[$];
    int arr_cyc[$];
    bit fetching, after_load;
    logic [PW-1:0] exp_pixel;
    logic          exp_uf, exp_mreq;
    logic [AW-1:0] exp_maddr;

    always @(negedge CLK) begin
        int tag, w;
        if (!RST_N) begin
            gen = 0; mcyc = 0; npix = 0; issued = 0;
            tagq.delete(); arr_cyc.delete();
            fetching = 0; after_load = 0;
            exp_pixel = '0; exp_uf = 1'b0; exp_mreq = 1'b0; exp_maddr = BASE;
        end else begin
            mcyc++;
            if (MVALID) begin
                tag = tagq.pop_front();
                if (tag == gen && !LOAD) arr_cyc.push_back(mcyc);
            end
            if (RDENABLE && !LOAD) begin
                w = npix / PPW;
                if (w < arr_cyc.size() && arr_cyc[w] < mcyc) begin
                    exp_pixel = pix_of(w, npix % PPW);
                    npix++;
                end else begin
                    exp_pixel = 8'h00;
                    exp_uf    = 1'b1;
                end
            end
            if (MREQ && MACK) begin
                tagq.push_back(gen);
                if (!LOAD) issued++;
            end
            if (LOAD) begin
                gen++; npix = 0; issued = 0; arr_cyc.delete();
                exp_uf = 1'b0; fetching = 1; after_load = 1;
            end else begin
                after_load = 0;
            end
            exp_mreq  = fetching && !after_load && issued < FRM && (issued - npix / PPW) < 16;
            exp_maddr = AW'(int'(BASE) + issued);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; LOAD = 1'b0; RDENABLE = 1'b0;
        repeat (3) tick();
        checks++; if (MREQ !== 1'b0) begin errors++; $display("FAIL reset_mreq got %0b want 0", MREQ); end
        checks++; if (MADDR !== BASE) begin errors++; $display("FAIL reset_maddr got %0h want %0h", MADDR, BASE); end
        checks++; if (PIXEL !== 8'h00) begin errors++; $display("FAIL reset_pixel got %0h want 00", PIXEL); end
        checks++; if (UNDERFLOW !== 1'b0) begin errors++; $display("FAIL reset_underflow got %0b want 0", UNDERFLOW); end
        RST_N = 1'b1;
        repeat (4) tick();
        checks++; if (MREQ !== 1'b0) begin errors++; $display("FAIL idle_mreq got %0b want 0", MREQ); end
    endtask

    task automatic test_fill();
        mem_lat = 2; ack_pct = 100;
        LOAD = 1'b1; tick(); LOAD = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++; if (MREQ !== exp_mreq) begin errors++; $display("FAIL fill_mreq cyc %0d got %0b want %0b", i, MREQ, exp_mreq); end
            if (exp_mreq) begin
                checks++; if (MADDR !== exp_maddr) begin errors++; $display("FAIL fill_maddr got %0h want %0h", MADDR, exp_maddr); end
            end
        end
        checks++; if (issued != 16) begin errors++; $display("FAIL fill_count got %0d want 16", issued); end
        checks++; if (MREQ !== 1'b0) begin errors++; $display("FAIL fill_full_mreq got %0b want 0", MREQ); end
        checks++; if (MADDR !== AW'(16)) begin errors++; $display("FAIL fill_maddr_end got %0h want 10", MADDR); end
    endtask

    task automatic test_stream();
        for (int i = 0; i <= 640; i++) begin
            tick();
            checks++; if (PIXEL !== exp_pixel) begin errors++; $display("FAIL stream_pixel i %0d got %0h want %0h", i, PIXEL, exp_pixel); end
            checks++; if (UNDERFLOW !== exp_uf) begin errors++; $display("FAIL stream_uf i %0d got %0b want %0b", i, UNDERFLOW, exp_uf); end
            checks++; if (MREQ !== exp_mreq) begin errors++; $display("FAIL stream_mreq i %0d got %0b want %0b", i, MREQ, exp_mreq); end
            if (i == 1) begin
                checks++; if (PIXEL !== pix_of(0, 0)) begin errors++; $display("FAIL stream_first got %0h want %0h", PIXEL, pix_of(0, 0)); end
            end
            RDENABLE = (i < 640);
        end
        tick();
        checks++; if (PIXEL !== pix_of(159, 3)) begin errors++; $display("FAIL stream_hold got %0h want %0h", PIXEL, pix_of(159, 3)); end
        checks++; if (UNDERFLOW !== 1'b0) begin errors++; $display("FAIL stream_no_uf got %0b want 0", UNDERFLOW); end
    endtask

    task automatic test_full_frame();
        int n = 0;
        ack_pct = 70;
        LOAD = 1'b1; tick(); LOAD = 1'b0;
        while (!(npix >= FRM * PPW && issued == FRM) && n < 8000) begin
            mem_lat  = $urandom_range(1, 8);
            RDENABLE = ($urandom_range(9) != 0);
            tick();
            n++;
            checks++; if (PIXEL !== exp_pixel) begin errors++; $display("FAIL frame_pixel n %0d got %0h want %0h", n, PIXEL, exp_pixel); end
            checks++; if (UNDERFLOW !== exp_uf) begin errors++; $display("FAIL frame_uf n %0d got %0b want %0b", n, UNDERFLOW, exp_uf); end
            checks++; if (MREQ !== exp_mreq) begin errors++; $display("FAIL frame_mreq n %0d got %0b want %0b", n, MREQ, exp_mreq); end
            if (exp_mreq) begin
                checks++; if (MADDR !== exp_maddr) begin errors++; $display("FAIL frame_maddr got %0h want %0h", MADDR, exp_maddr); end
            end
        end
        RDENABLE = 1'b0;
        checks++; if (n >= 8000) begin errors++; $display("FAIL frame_timeout pixels %0d want %0d", npix, FRM * PPW); end
        checks++; if (issued != FRM) begin errors++; $display("FAIL frame_requests got %0d want %0d", issued, FRM); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (MREQ !== 1'b0) begin errors++; $display("FAIL frame_done_mreq got %0b want 0", MREQ); end
        end
        checks++; if (dut.state_q !== DONE) begin errors++; $display("FAIL frame_state got %0d want %0d", dut.state_q, DONE); end
    endtask

    task automatic test_latency();
        mem_lat = 40; ack_pct = 100;
        LOAD = 1'b1; tick(); LOAD = 1'b0;
        RDENABLE = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            checks++; if (PIXEL !== exp_pixel) begin errors++; $display("FAIL lat_pixel i %0d got %0h want %0h", i, PIXEL, exp_pixel); end
            checks++; if (UNDERFLOW !== exp_uf) begin errors++; $display("FAIL lat_uf i %0d got %0b want %0b", i, UNDERFLOW, exp_uf); end
            if (i == 5) begin
                checks++; if (PIXEL !== 8'h00 || UNDERFLOW !== 1'b1) begin errors++; $display("FAIL lat_underrun got %0h/%0b want 00/1", PIXEL, UNDERFLOW); end
            end
        end
        RDENABLE = 1'b0;
        repeat (10) tick();
        checks++; if (UNDERFLOW !== 1'b1) begin errors++; $display("FAIL lat_sticky got %0b want 1", UNDERFLOW); end
    endtask

    task automatic test_load_mid();
        int n = 0;
        mem_lat = 6; ack_pct = 100;
        LOAD = 1'b1; tick(); LOAD = 1'b0;
        checks++; if (UNDERFLOW !== 1'b0) begin errors++; $display("FAIL load_clears_uf got %0b want 0", UNDERFLOW); end
        while ((issued - arr_cyc.size()) != 6 && n < 50) begin
            tick();
            n++;
            checks++; if (MREQ !== exp_mreq) begin errors++; $display("FAIL mid_mreq got %0b want %0b", MREQ, exp_mreq); end
        end
        checks++; if (n >= 50) begin errors++; $display("FAIL mid_timeout outstanding %0d want 6", issued - arr_cyc.size()); end
        LOAD = 1'b1; tick(); LOAD = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++; if (MREQ !== exp_mreq) begin errors++; $display("FAIL mid_refetch_mreq got %0b want %0b", MREQ, exp_mreq); end
            if (exp_mreq) begin
                checks++; if (MADDR !== exp_maddr) begin errors++; $display("FAIL mid_maddr got %0h want %0h", MADDR, exp_maddr); end
            end
        end
        RDENABLE = 1'b1; tick(); RDENABLE = 1'b0;
        checks++; if (PIXEL !== pix_of(0, 0)) begin errors++; $display("FAIL mid_first_pixel got %0h want %0h", PIXEL, pix_of(0, 0)); end
        checks++; if (PIXEL !== exp_pixel) begin errors++; $display("FAIL mid_model_pixel got %0h want %0h", PIXEL, exp_pixel); end
    endtask

    task automatic test_back_to_back();
        LOAD = 1'b1; tick(); tick(); LOAD = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            ack_pct  = $urandom_range(40, 100);
            mem_lat  = $urandom_range(1, 10);
            RDENABLE = ($urandom_range(3) != 0);
            LOAD     = ($urandom_range(299) == 0);
            tick();
            checks++; if (PIXEL !== exp_pixel) begin errors++; $display("FAIL b2b_pixel i %0d got %0h want %0h", i, PIXEL, exp_pixel); end
            checks++; if (UNDERFLOW !== exp_uf) begin errors++; $display("FAIL b2b_uf i %0d got %0b want %0b", i, UNDERFLOW, exp_uf); end
            checks++; if (MREQ !== exp_mreq) begin errors++; $display("FAIL b2b_mreq i %0d got %0b want %0b", i, MREQ, exp_mreq); end
            if (exp_mreq) begin
                checks++; if (MADDR !== exp_maddr) begin errors++; $display("FAIL b2b_maddr got %0h want %0h", MADDR, exp_maddr); end
            end
        end
        LOAD = 1'b0; RDENABLE = 1'b0;
    endtask

    task automatic test_async_reset();
        mem_lat = 2; ack_pct = 100;
        LOAD = 1'b1; tick(); LOAD = 1'b0;
        repeat (40) tick();
        ack_pct = 0;
        RDENABLE = 1'b1; repeat (4) tick(); RDENABLE = 1'b0;
        checks++; if (MREQ !== 1'b1) begin errors++; $display("FAIL pre_reset_mreq got %0b want 1", MREQ); end
        checks++; if (PIXEL !== pix_of(0, 3)) begin errors++; $display("FAIL pre_reset_pixel got %0h want %0h", PIXEL, pix_of(0, 3)); end
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (MREQ !== 1'b0) begin errors++; $display("FAIL async_mreq got %0b want 0", MREQ); end
        checks++; if (PIXEL !== 8'h00) begin errors++; $display("FAIL async_pixel got %0h want 00", PIXEL); end
        checks++; if (UNDERFLOW !== 1'b0) begin errors++; $display("FAIL async_uf got %0b want 0", UNDERFLOW); end
        repeat (3) tick();
        RST_N = 1'b1; ack_pct = 100;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (MREQ !== 1'b0) begin errors++; $display("FAIL post_reset_mreq i %0d got %0b want 0", i, MREQ); end
        end
    endtask

    initial begin
        RST_N = 1'b0; LOAD = 1'b0; RDENABLE = 1'b0;
        MACK = 1'b0; MVALID = 1'b0; MDATA = '0;
        test_reset();
        test_fill();
        test_stream();
        test_full_frame();
        test_latency();
        test_load_mid();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
